// File: rtl/if_fetch_stage_if.sv
// Bundles the fetch stage's control inputs, imem port and IF/ID outputs.
interface if_fetch_stage_if;
    logic        load_busy;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_code;
    logic [31:0] imem_addr;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_inst;
    logic        fetch_fault;

    // Fetch stage side.
    modport slave (
        input  load_busy, stall, redirect_valid, redirect_pc, inst_code,
        output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_inst, fetch_fault
    );

    // Environment side (control, imem model, decode).
    modport master (
        output load_busy, stall, redirect_valid, redirect_pc, inst_code,
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_inst, fetch_fault
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the imem word address, and
// registers the returned instruction into IF/ID. Handles stall, redirect
// flush, the imem load window, and misaligned/out-of-range fetch faults.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_MAX   = 32'h07FF_FFFC,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    if_fetch_stage_if.slave bus
);

    localparam logic [1:0] S_LOAD_WAIT = 2'd0;
    localparam logic [1:0] S_FETCH     = 2'd1;
    localparam logic [1:0] S_FAULT     = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc_p0;
    logic        r_vld_p1;
    logic [31:0] r_ifid_pc_p1;
    logic [31:0] r_ifid_pc4_p1;
    logic [31:0] r_ifid_inst_p1;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic        w_pc_bad;

    // Next sequential address wraps modulo 2^32; overflow is caught by w_pc_bad.
    assign w_pc_plus4 = r_pc_p0 + 32'd4;
    assign w_pc_bad   = (r_pc_p0[1:0] != 2'b00) || (r_pc_p0 > PC_MAX);

    // imem address is the PC register only; no input reaches it combinationally.
    assign bus.imem_addr     = r_pc_p0;
    assign bus.ifid_valid    = r_vld_p1;
    assign bus.ifid_pc       = r_ifid_pc_p1;
    assign bus.ifid_pc_plus4 = r_ifid_pc4_p1;
    assign bus.ifid_inst     = r_ifid_inst_p1;
    assign bus.fetch_fault   = r_fault;

    // FSM, PC and IF/ID register update in priority order load > redirect > fault > stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_LOAD_WAIT;
            r_pc_p0        <= RESET_PC;
            r_vld_p1       <= 1'b0;
            r_ifid_pc_p1   <= 32'd0;
            r_ifid_pc4_p1  <= 32'd0;
            r_ifid_inst_p1 <= NOP_INST;
            r_fault        <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_WAIT: begin
                    r_vld_p1 <= 1'b0;
                    r_pc_p0  <= RESET_PC;
                    if (!bus.load_busy) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.load_busy) begin
                        r_state        <= S_LOAD_WAIT;
                        r_pc_p0        <= RESET_PC;
                        r_vld_p1       <= 1'b0;
                        r_ifid_inst_p1 <= NOP_INST;
                    end else if (bus.redirect_valid) begin
                        r_pc_p0        <= bus.redirect_pc;
                        r_vld_p1       <= 1'b0;
                        r_ifid_inst_p1 <= NOP_INST;
                    end else if (w_pc_bad) begin
                        // inst_code for a bad address is never captured.
                        r_state  <= S_FAULT;
                        r_fault  <= 1'b1;
                        r_vld_p1 <= 1'b0;
                    end else if (!bus.stall) begin
                        r_ifid_pc_p1   <= r_pc_p0;
                        r_ifid_pc4_p1  <= w_pc_plus4;
                        r_ifid_inst_p1 <= bus.inst_code;
                        r_vld_p1       <= 1'b1;
                        r_pc_p0        <= w_pc_plus4;
                    end
                end
                S_FAULT: begin
                    r_vld_p1 <= 1'b0;
                    if (bus.load_busy) begin
                        r_state        <= S_LOAD_WAIT;
                        r_pc_p0        <= RESET_PC;
                        r_fault        <= 1'b0;
                        r_ifid_inst_p1 <= NOP_INST;
                    end else if (bus.redirect_valid) begin
                        r_state        <= S_FETCH;
                        r_pc_p0        <= bus.redirect_pc;
                        r_fault        <= 1'b0;
                        r_ifid_inst_p1 <= NOP_INST;
                    end
                end
                default: begin
                    r_state  <= S_LOAD_WAIT;
                    r_pc_p0  <= RESET_PC;
                    r_vld_p1 <= 1'b0;
                    r_fault  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table plus async-reset sequence.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory image: three preloaded words, a tagged pattern elsewhere.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_0113;
            32'h8:   return 32'h0020_81B3;
            default: return 32'hC000_0000 | a;
        endcase
    endfunction

    assign bus.inst_code = imem_word(bus.imem_addr);

    typedef struct {
        logic        lb;
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_inst;
        logic        e_flt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic lb, input logic st, input logic rv,
                                input logic [31:0] rpc, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc,
                                input logic [31:0] p4, input logic [31:0] inst,
                                input logic flt);
        vec_t v;
        v.lb = lb; v.st = st; v.rv = rv; v.rpc = rpc;
        v.e_addr = addr; v.e_vld = vld; v.e_pc = pc; v.e_p4 = p4;
        v.e_inst = inst; v.e_flt = flt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [31:0] addr, input logic vld,
                           input logic [31:0] pc, input logic [31:0] p4,
                           input logic [31:0] inst, input logic flt);
        chk("imem_addr", idx, bus.imem_addr, addr);
        chk("ifid_valid", idx, {31'd0, bus.ifid_valid}, {31'd0, vld});
        chk("ifid_pc", idx, bus.ifid_pc, pc);
        chk("ifid_pc_plus4", idx, bus.ifid_pc_plus4, p4);
        chk("ifid_inst", idx, bus.ifid_inst, inst);
        chk("fetch_fault", idx, {31'd0, bus.fetch_fault}, {31'd0, flt});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        bus.load_busy      = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;

        // Load window: 10 cycles with imem being written, PC parked at 0.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1,0,0,0,      32'h0, 0, 32'h0, 32'h0, NOP, 0));
        // Load ends: one edge to enter FETCH, valid on the next.
        vecs.push_back(mk(0,0,0,0,          32'h0, 0, 32'h0, 32'h0, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h4, 1, 32'h0, 32'h4, 32'h0010_0093, 0));
        vecs.push_back(mk(0,0,0,0,          32'h8, 1, 32'h4, 32'h8, 32'h0020_0113, 0));
        // Stall three cycles with pc=8.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,0,0,      32'h8, 1, 32'h4, 32'h8, 32'h0020_0113, 0));
        vecs.push_back(mk(0,0,0,0,          32'hC, 1, 32'h8, 32'hC, 32'h0020_81B3, 0));
        // Redirect overrides stall: one bubble, then target fetched.
        vecs.push_back(mk(0,1,1,32'h40,     32'h40, 0, 32'h8, 32'hC, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h44, 1, 32'h40, 32'h44, 32'hC000_0040, 0));
        // Misaligned target faults one edge after it reaches the PC.
        vecs.push_back(mk(0,0,1,32'h42,     32'h42, 0, 32'h40, 32'h44, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h42, 0, 32'h40, 32'h44, NOP, 1));
        vecs.push_back(mk(0,1,0,0,          32'h42, 0, 32'h40, 32'h44, NOP, 1));
        // Redirect out of the fault.
        vecs.push_back(mk(0,0,1,32'h100,    32'h100, 0, 32'h40, 32'h44, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h104, 1, 32'h100, 32'h104, 32'hC000_0100, 0));
        // Increment past PC_MAX.
        vecs.push_back(mk(0,0,1,32'h07FF_FFF8, 32'h07FF_FFF8, 0, 32'h100, 32'h104, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h07FF_FFFC, 1, 32'h07FF_FFF8, 32'h07FF_FFFC, 32'hC7FF_FFF8, 0));
        vecs.push_back(mk(0,0,0,0,          32'h0800_0000, 1, 32'h07FF_FFFC, 32'h0800_0000, 32'hC7FF_FFFC, 0));
        vecs.push_back(mk(0,0,0,0,          32'h0800_0000, 0, 32'h07FF_FFFC, 32'h0800_0000, 32'hC7FF_FFFC, 1));
        // Recover and run to pc=0x20.
        vecs.push_back(mk(0,0,1,32'h1C,     32'h1C, 0, 32'h07FF_FFFC, 32'h0800_0000, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h20, 1, 32'h1C, 32'h20, 32'hC000_001C, 0));
        // Load together with redirect: load wins.
        vecs.push_back(mk(1,0,1,32'h80,     32'h0, 0, 32'h1C, 32'h20, NOP, 0));
        vecs.push_back(mk(1,0,0,0,          32'h0, 0, 32'h1C, 32'h20, NOP, 0));
        vecs.push_back(mk(1,0,0,0,          32'h0, 0, 32'h1C, 32'h20, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h0, 0, 32'h1C, 32'h20, NOP, 0));
        vecs.push_back(mk(0,0,0,0,          32'h4, 1, 32'h0, 32'h4, 32'h0010_0093, 0));

        // Reset state while rst_n is held low.
        @(posedge clk);
        #1;
        chk_all(-1, 32'h0, 0, 32'h0, 32'h0, NOP, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.load_busy      = vecs[i].lb;
            bus.stall          = vecs[i].st;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_pc,
                    vecs[i].e_p4, vecs[i].e_inst, vecs[i].e_flt);
        end

        // Fetch once more so IF/ID holds non-reset values, then pulse rst_n between edges.
        bus.load_busy = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all(100, 32'h8, 1, 32'h4, 32'h8, 32'h0020_0113, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(101, 32'h0, 0, 32'h0, 32'h0, NOP, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all(102, 32'h0, 0, 32'h0, 32'h0, NOP, 0);
        @(posedge clk);
        #1;
        chk_all(103, 32'h4, 1, 32'h0, 32'h4, 32'h0010_0093, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
